grant_arbiter_n: RTL and testbench

GRANT_ARBITER_N -- requirements
Module: grant_arbiter_n

---
 rtl/arb_pkg.sv | 8 +
 rtl/arb_pick.sv | 27 ++
 rtl/grant_arbiter_n.sv | 109 ++++++++++
 tb/tb_grant_arbiter_n.sv | 127 ++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state, arbitration mode codes and hold-counter width
// for grant_arbiter_n and its priority picker.
package arb_pkg;
    typedef enum logic {IDLE, GRANT} state_t;
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR = 1;
    localparam int CNT_W = 8;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational priority search starting at index start with wrap-around;
// masked requesters lose unless nobody else is asking.
module arb_pick #(
    parameter int N = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);
    logic [N-1:0] cand;
    always_comb begin
        cand = (|(req & ~mask)) ? (req & ~mask) : req;
        onehot = '0;
        idx = '0;
        // scan from farthest to nearest so the first hit after start is written last
        for (int k = N - 1; k >= 0; k--) begin
            if (cand[IW'((int'(start) + k) % N)]) begin
                onehot = '0;
                onehot[IW'((int'(start) + k) % N)] = 1'b1;
                idx = IW'((int'(start) + k) % N);
            end
        end
    end
endmodule

// File: rtl/grant_arbiter_n.sv
// grant_arbiter_n: N-way IDLE/GRANT arbiter, fixed priority or round-robin, registered grants.
// Define GRANT_ARBITER_N_TIMEOUT_EN to compile in the MAX_HOLD tenure timer.
module grant_arbiter_n
    import arb_pkg::*;
#(
    parameter int N = 4,
    parameter int MODE = MODE_FIXED,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         r,
    output logic [N-1:0]         g,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 timeout
);
    localparam int IW = $clog2(N);
    state_t state, state_n;
    logic [N-1:0] g_n, win, mask;
    logic [IW-1:0] owner_n, ptr, ptr_n, start, win_idx;
    if (N < 2 || N > 16) begin : g_bad_n
        $error("grant_arbiter_n: N must be 2..16");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("grant_arbiter_n: MAX_HOLD must be 1..255");
    end
    assign start = (MODE == MODE_RR) ? ((ptr == IW'(N - 1)) ? '0 : ptr + 1'b1) : '0;
    assign busy = (state == GRANT);
    arb_pick #(.N(N), .IW(IW)) u_pick (
        .req(r),
        .start(start),
        .mask(mask),
        .onehot(win),
        .idx(win_idx)
    );
`ifdef GRANT_ARBITER_N_TIMEOUT_EN
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [N-1:0] mask_n;
    logic timeout_n;
`endif
    always_comb begin
        state_n = state;
        g_n = g;
        owner_n = owner;
        ptr_n = ptr;
`ifdef GRANT_ARBITER_N_TIMEOUT_EN
        cnt_n = cnt;
        mask_n = '0;
        timeout_n = 1'b0;
`endif
        if (state == IDLE) begin
            if (|r) begin
                state_n = GRANT;
                g_n = win;
                owner_n = win_idx;
                ptr_n = (MODE == MODE_RR) ? win_idx : ptr;
`ifdef GRANT_ARBITER_N_TIMEOUT_EN
                cnt_n = CNT_W'(1);
`endif
            end
        end else if (!r[owner]) begin
            state_n = IDLE;
            g_n = '0;
            owner_n = '0;
        end
`ifdef GRANT_ARBITER_N_TIMEOUT_EN
        // a release in the same cycle wins over the forced release
        else if (cnt == CNT_W'(MAX_HOLD)) begin
            state_n = IDLE;
            g_n = '0;
            owner_n = '0;
            timeout_n = 1'b1;
            mask_n = g;
        end else begin
            cnt_n = cnt + 1'b1;
        end
`endif
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            g <= '0;
            owner <= '0;
            ptr <= IW'(N - 1);
        end else begin
            state <= state_n;
            g <= g_n;
            owner <= owner_n;
            ptr <= ptr_n;
        end
    end
`ifdef GRANT_ARBITER_N_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            mask <= '0;
            timeout <= 1'b0;
        end else begin
            cnt <= cnt_n;
            mask <= mask_n;
            timeout <= timeout_n;
        end
    end
`else
    assign mask = '0;
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_grant_arbiter_n.sv
// tb_grant_arbiter_n: table-driven and hand-sequenced checks of a fixed-priority and a
// round-robin instance (N=4, MAX_HOLD=3), with a scoreboard of expected grants.
module tb_grant_arbiter_n;
    import arb_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] r0 = '0, r1 = '0, g0, g1;
    logic [1:0] o0, o1;
    logic b0, b1, t0, t1;
    int n_vec = 0, n_bad = 0;
`ifdef GRANT_ARBITER_N_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif
    typedef struct packed {
        logic [3:0] r0, r1, g0, g1;
        logic t0, t1;
    } vec_t;
    vec_t tbl [22];
    vec_t sb [$];
    always #5 clk = ~clk;
    grant_arbiter_n #(.N(4), .MODE(MODE_FIXED), .MAX_HOLD(3)) u_fix (
        .clk(clk), .reset(reset), .r(r0), .g(g0), .owner(o0), .busy(b0), .timeout(t0)
    );
    grant_arbiter_n #(.N(4), .MODE(MODE_RR), .MAX_HOLD(3)) u_rr (
        .clk(clk), .reset(reset), .r(r1), .g(g1), .owner(o1), .busy(b1), .timeout(t1)
    );
    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [1:0] idx_of(input logic [3:0] v);
        idx_of = 2'd0;
        for (int i = 0; i < 4; i++) if (v[i]) idx_of = 2'(i);
    endfunction
    task automatic check_all(input vec_t e);
        cmp("fix.g", g0, e.g0);
        cmp("fix.owner", {2'b00, o0}, {2'b00, idx_of(e.g0)});
        cmp("fix.busy", {3'b000, b0}, {3'b000, |e.g0});
        cmp("fix.timeout", {3'b000, t0}, {3'b000, e.t0});
        cmp("rr.g", g1, e.g1);
        cmp("rr.owner", {2'b00, o1}, {2'b00, idx_of(e.g1)});
        cmp("rr.busy", {3'b000, b1}, {3'b000, |e.g1});
        cmp("rr.timeout", {3'b000, t1}, {3'b000, e.t1});
    endtask
    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic [3:0] ea,
                        input logic [3:0] eb, input logic ta, input logic tb);
        vec_t e;
        r0 = a;
        r1 = b;
        sb.push_back('{a, b, ea, eb, ta, tb});
        @(negedge clk);
        e = sb.pop_front();
        check_all(e);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end
    initial begin
        tbl[0]  = '{4'b0110, 4'b1111, 4'b0010, 4'b0001, 1'b0, 1'b0};
        tbl[1]  = '{4'b0110, 4'b1111, 4'b0010, 4'b0001, 1'b0, 1'b0};
        tbl[2]  = '{4'b0100, 4'b1110, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[3]  = '{4'b0100, 4'b1111, 4'b0100, 4'b0010, 1'b0, 1'b0};
        tbl[4]  = '{4'b0100, 4'b1111, 4'b0100, 4'b0010, 1'b0, 1'b0};
        tbl[5]  = '{4'b0000, 4'b1101, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{4'b1010, 4'b1111, 4'b0010, 4'b0100, 1'b0, 1'b0};
        tbl[7]  = '{4'b1010, 4'b1111, 4'b0010, 4'b0100, 1'b0, 1'b0};
        tbl[8]  = '{4'b1000, 4'b1011, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[9]  = '{4'b1001, 4'b1111, 4'b0001, 4'b1000, 1'b0, 1'b0};
        tbl[10] = '{4'b1000, 4'b1111, 4'b0000, 4'b1000, 1'b0, 1'b0};
        tbl[11] = '{4'b1000, 4'b0111, 4'b1000, 4'b0000, 1'b0, 1'b0};
        tbl[12] = '{4'b0000, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0};
        tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[14] = '{4'b1100, 4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0};
        tbl[15] = '{4'b1100, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0};
        tbl[16] = '{4'b1000, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0};
        tbl[17] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b0};
        tbl[18] = '{4'b0000, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0};
        tbl[19] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[20] = '{4'b0000, 4'b1111, 4'b0000, 4'b1000, 1'b0, 1'b0};
        tbl[21] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        repeat (2) @(negedge clk);
        check_all('0);
        reset = 1'b0;
        foreach (tbl[i]) step(tbl[i].r0, tbl[i].r1, tbl[i].g0, tbl[i].g1, tbl[i].t0, tbl[i].t1);
        // asynchronous reset in the middle of a tenure, then re-arbitration
        step(4'b1000, 4'b1000, 4'b1000, 4'b1000, 1'b0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_all('0);
        @(negedge clk);
        reset = 1'b0;
        step(4'b1000, 4'b1000, 4'b1000, 4'b1000, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // move the round-robin pointer to 1, then reset must bring the first grant back to 0
        step(4'b0000, 4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_all('0);
        reset = 1'b0;
        step(4'b1111, 4'b1111, 4'b0001, 4'b0001, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // long holds: forced release with masking when the timer is built in
        repeat (3) step(4'b0011, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0);
        step(4'b0011, 4'b0000, TO ? 4'b0000 : 4'b0001, 4'b0000, TO, 1'b0);
        step(4'b0011, 4'b0000, TO ? 4'b0010 : 4'b0001, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        repeat (3) step(4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0);
        step(4'b0001, 4'b0000, TO ? 4'b0000 : 4'b0001, 4'b0000, TO, 1'b0);
        step(4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // owner drops exactly when the hold limit is reached: plain release, no mask
        repeat (3) step(4'b0011, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0);
        step(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        step(4'b0011, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
